// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the fetch and decode stages.
// Provides the default instruction/PC widths, the HALT opcode, the NOP
// encoding and the fetch-stage state enum.
package cpu_pkg;

   localparam int unsigned INSTR_W = 19;
   localparam int unsigned PC_W    = 8;
   localparam int unsigned OP_W    = 5;

   localparam logic [OP_W-1:0]    OP_HALT = 5'b11111;
   localparam logic [INSTR_W-1:0] NOP     = '0;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// Combinational PC next-value mux: redirect, increment or hold.
// Ports:
//   pc        - current fetch address
//   advance   - take pc + 1 (wrapping)
//   redirect  - take target; wins over advance
//   target    - redirect address
//   pc_nxt_c  - selected next fetch address
module pc_next
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W = cpu_pkg::PC_W
) (
   input  logic [PC_W-1:0] pc,
   input  logic            advance,
   input  logic            redirect,
   input  logic [PC_W-1:0] target,
   output logic [PC_W-1:0] pc_nxt_c
);

   // Redirect has priority over both advance and stall.
   always_comb begin
      pc_nxt_c = pc;
      if (redirect) begin
         pc_nxt_c = target;
      end else if (advance) begin
         pc_nxt_c = pc + PC_W'(1);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the synchronous instruction memory,
// presents fetched instructions to IF/ID, handles stalls, redirects and
// the HALT instruction.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   PCwrite           - 1 = advance fetch, 0 = stall
//   branch_taken      - redirect request from a later stage
//   branch_target     - redirect address
//   imem_addr         - instruction memory read address (= pc_q)
//   imem_en           - instruction memory read enable
//   imem_rdata        - memory data, valid one cycle after an enabled read
//   next_instruction  - instruction to IF/ID (NOP when not valid)
//   pc_plus_one_IF    - address of next_instruction plus one
//   halted            - high once HALT has been retired into IF/ID
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned INSTR_W = cpu_pkg::INSTR_W,
   parameter int unsigned PC_W    = cpu_pkg::PC_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               PCwrite,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   output logic [PC_W-1:0]    imem_addr,
   output logic               imem_en,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] next_instruction,
   output logic [PC_W-1:0]    pc_plus_one_IF,
   output logic               halted
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d1;
   logic [PC_W-1:0] pc_nxt_c;
   logic            fetch_valid;
   fetch_state_e    state;
   logic            halt_hit_c;
   logic            advance_c;

   // A valid HALT on the memory port retires only when IF/ID accepts it
   // and no redirect squashes it in the same cycle.
   assign halt_hit_c = fetch_valid
                       && (imem_rdata[INSTR_W-1 -: OP_W] == OP_HALT)
                       && PCwrite && !branch_taken;
   assign advance_c  = PCwrite && !halt_hit_c;

   pc_next #(.PC_W(PC_W)) u_pc_next (
      .pc       (pc_q),
      .advance  (advance_c),
      .redirect (branch_taken),
      .target   (branch_target),
      .pc_nxt_c (pc_nxt_c)
   );

   assign imem_addr        = pc_q;
   assign imem_en          = rst_n && (state == RUN) && (PCwrite || branch_taken);
   assign next_instruction = fetch_valid ? imem_rdata : INSTR_W'(NOP);
   assign pc_plus_one_IF   = pc_d1 + PC_W'(1);
   assign halted           = (state == HALT);

   // Fetch state: PC pipeline, valid flag and RUN/HALT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= '0;
         pc_d1       <= '0;
         fetch_valid <= 1'b0;
         state       <= RUN;
      end else if (state == RUN) begin
         pc_q <= pc_nxt_c;
         if (branch_taken) begin
            fetch_valid <= 1'b0;
         end else if (halt_hit_c) begin
            fetch_valid <= 1'b0;
            state       <= HALT;
         end else if (PCwrite) begin
            pc_d1       <= pc_q;
            fetch_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// HALT/reset sequences and a randomized run against an address-level model.
module tb_fetch_unit;

   localparam int unsigned IW = 19;
   localparam int unsigned PW = 8;
   localparam logic [IW-1:0] HALT_INSTR = 19'h7C000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pc_write;
   logic          branch_taken;
   logic [PW-1:0] branch_target;
   logic [PW-1:0] imem_addr;
   logic          imem_en;
   logic [IW-1:0] imem_rdata;
   logic [IW-1:0] next_instruction;
   logic [PW-1:0] pc_plus_one_IF;
   logic          halted;

   logic [IW-1:0] rom [256];

   int errors = 0;
   int checks = 0;

   // Reference model state, in address terms.
   logic [PW-1:0] m_fetch;
   logic [PW-1:0] m_shown;
   logic          m_valid;
   logic          m_halted;

   fetch_unit dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .PCwrite          (pc_write),
      .branch_taken     (branch_taken),
      .branch_target    (branch_target),
      .imem_addr        (imem_addr),
      .imem_en          (imem_en),
      .imem_rdata       (imem_rdata),
      .next_instruction (next_instruction),
      .pc_plus_one_IF   (pc_plus_one_IF),
      .halted           (halted)
   );

   always #5 clk = ~clk;

   // Synchronous instruction memory; holds data when not enabled.
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= rom[imem_addr];
   end

   typedef struct {
      logic          pw;
      logic          br;
      logic [PW-1:0] tgt;
      logic [IW-1:0] instr;
      logic [PW-1:0] ppo;
      logic [PW-1:0] addr;
      logic          en;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic pw, input logic br, input logic [PW-1:0] tgt);
      pc_write      = pw;
      branch_taken  = br;
      branch_target = tgt;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic fill_rom_identity();
      for (int i = 0; i < 256; i++) rom[i] = IW'(i);
   endtask

   // Reset held across one clock edge, released at a falling edge.
   task automatic do_reset();
      drive(1'b0, 1'b0, 8'h00);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, ".instr"}, 32'(next_instruction), 32'd0);
      chk({tag, ".ppo"},   32'(pc_plus_one_IF),   32'd1);
      chk({tag, ".addr"},  32'(imem_addr),        32'd0);
      chk({tag, ".en"},    32'(imem_en),          32'd0);
      chk({tag, ".halted"}, 32'(halted),          32'd0);
   endtask

   function automatic void model_reset();
      m_fetch  = '0;
      m_shown  = '0;
      m_valid  = 1'b0;
      m_halted = 1'b0;
   endfunction

   function automatic void model_step(input logic pw, input logic br, input logic [PW-1:0] tgt);
      if (m_halted) return;
      if (br) begin
         m_fetch = tgt;
         m_valid = 1'b0;
      end else if (pw) begin
         if (m_valid && rom[m_shown][IW-1 -: 5] == 5'b11111) begin
            m_halted = 1'b1;
            m_valid  = 1'b0;
         end else begin
            m_shown = m_fetch;
            m_fetch = m_fetch + 8'd1;
            m_valid = 1'b1;
         end
      end
   endfunction

   initial begin
      rst_n         = 1'b1;
      pc_write      = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;
      fill_rom_identity();

      // Asynchronous reset check before any clock edge is needed.
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b1, 1'b0, 8'h00);
      check_reset_values("reset0");
      do_reset();

      // Directed vectors: outputs are checked with the row's inputs applied,
      // just before the rising edge that consumes them.
      tbl[0]  = '{1'b1, 1'b0, 8'h00, 19'd0,    8'h01, 8'h00, 1'b1};
      tbl[1]  = '{1'b1, 1'b0, 8'h00, 19'd0,    8'h01, 8'h01, 1'b1};
      tbl[2]  = '{1'b1, 1'b0, 8'h00, 19'd1,    8'h02, 8'h02, 1'b1};
      tbl[3]  = '{1'b1, 1'b0, 8'h00, 19'd2,    8'h03, 8'h03, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 8'h00, 19'd3,    8'h04, 8'h04, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 8'h00, 19'd3,    8'h04, 8'h04, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 8'h00, 19'd3,    8'h04, 8'h04, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 8'h40, 19'd4,    8'h05, 8'h05, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 8'h00, 19'd0,    8'h05, 8'h40, 1'b1};
      tbl[9]  = '{1'b1, 1'b1, 8'hFF, 19'h40,   8'h41, 8'h41, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 8'h00, 19'd0,    8'h41, 8'hFF, 1'b1};
      tbl[11] = '{1'b1, 1'b0, 8'h00, 19'hFF,   8'h00, 8'h00, 1'b1};
      tbl[12] = '{1'b1, 1'b0, 8'h00, 19'd0,    8'h01, 8'h01, 1'b1};
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].pw, tbl[i].br, tbl[i].tgt);
         chk($sformatf("tbl%0d.instr", i),  32'(next_instruction), 32'(tbl[i].instr));
         chk($sformatf("tbl%0d.ppo", i),    32'(pc_plus_one_IF),   32'(tbl[i].ppo));
         chk($sformatf("tbl%0d.addr", i),   32'(imem_addr),        32'(tbl[i].addr));
         chk($sformatf("tbl%0d.en", i),     32'(imem_en),          32'(tbl[i].en));
         chk($sformatf("tbl%0d.halted", i), 32'(halted),           32'd0);
         tick();
      end

      // Mid-run asynchronous reset: outputs must drop without a clock edge.
      drive(1'b1, 1'b0, 8'h00);
      rst_n = 1'b0;
      #1;
      check_reset_values("midrun_rst");
      tick();
      rst_n = 1'b1;
      #1;

      // HALT at address 5, first presented during a stall (deferred).
      rom[5] = HALT_INSTR;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 1'b0, 8'h00);
         chk($sformatf("halt_run%0d.instr", k), 32'(next_instruction),
             (k == 0) ? 32'd0 : 32'(k - 1));
         tick();
      end
      drive(1'b0, 1'b0, 8'h00);
      chk("halt_defer.instr",  32'(next_instruction), 32'(HALT_INSTR));
      chk("halt_defer.halted", 32'(halted), 32'd0);
      chk("halt_defer.en",     32'(imem_en), 32'd0);
      tick();
      drive(1'b1, 1'b0, 8'h00);
      chk("halt_present.instr",  32'(next_instruction), 32'(HALT_INSTR));
      chk("halt_present.halted", 32'(halted), 32'd0);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(k != 1, 1'b1, 8'h10);
         chk($sformatf("halted%0d.instr", k),  32'(next_instruction), 32'd0);
         chk($sformatf("halted%0d.halted", k), 32'(halted), 32'd1);
         chk($sformatf("halted%0d.en", k),     32'(imem_en), 32'd0);
         tick();
      end

      // Reset while halted, then redirect racing the HALT on the memory port.
      drive(1'b1, 1'b0, 8'h00);
      rst_n = 1'b0;
      #1;
      check_reset_values("halt_rst");
      tick();
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 1'b0, 8'h00);
         if (k == 1) chk("restart.instr", 32'(next_instruction), 32'd0);
         if (k == 1) chk("restart.ppo",   32'(pc_plus_one_IF),   32'd1);
         tick();
      end
      drive(1'b1, 1'b1, 8'h20);
      chk("race.instr", 32'(next_instruction), 32'(HALT_INSTR));
      tick();
      drive(1'b1, 1'b0, 8'h00);
      chk("race_after.halted", 32'(halted), 32'd0);
      chk("race_after.instr",  32'(next_instruction), 32'd0);
      chk("race_after.addr",   32'(imem_addr), 32'h20);
      tick();
      drive(1'b1, 1'b0, 8'h00);
      chk("race_tgt.instr", 32'(next_instruction), 32'h20);
      chk("race_tgt.ppo",   32'(pc_plus_one_IF),   32'h21);
      tick();

      // Randomized run against the model; ROM content fixed for the run.
      for (int i = 0; i < 256; i++) begin
         rom[i] = IW'($urandom);
         if ($urandom_range(0, 7) == 0) rom[i][IW-1 -: 5] = 5'b11111;
      end
      do_reset();
      model_reset();
      for (int c = 0; c < 600; c++) begin
         logic          pw;
         logic          br;
         logic [PW-1:0] tgt;
         if ($urandom_range(0, 99) < 3) begin
            rst_n = 1'b0;
            #1;
            check_reset_values($sformatf("rnd%0d.rst", c));
            rst_n = 1'b1;
            model_reset();
         end
         pw  = ($urandom_range(0, 3) != 0);
         br  = ($urandom_range(0, 9) == 0);
         tgt = PW'($urandom);
         drive(pw, br, tgt);
         chk($sformatf("rnd%0d.instr", c),  32'(next_instruction),
             m_valid ? 32'(rom[m_shown]) : 32'd0);
         chk($sformatf("rnd%0d.ppo", c),    32'(pc_plus_one_IF), 32'(8'(m_shown + 8'd1)));
         chk($sformatf("rnd%0d.addr", c),   32'(imem_addr), 32'(m_fetch));
         chk($sformatf("rnd%0d.en", c),     32'(imem_en), 32'(!m_halted && (pw || br)));
         chk($sformatf("rnd%0d.halted", c), 32'(halted), 32'(m_halted));
         tick();
         model_step(pw, br, tgt);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter INSTR_W, default 19: instruction width.
REQ-002 SHALL have parameter PC_W, default 8: PC / instruction-memory address width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port PCwrite, input, 1: 1 = advance fetch, 0 = stall; driven by the hazard unit alongside IF_IDwrite.
REQ-006 SHALL have port branch_taken, input, 1: redirect request from a later stage.
REQ-007 SHALL have port branch_target, input, PC_W: redirect address.
REQ-008 SHALL have port imem_addr, output, PC_W: instruction-memory read address.
REQ-009 SHALL have port imem_en, output, 1: memory read enable; memory holds imem_rdata when low.
REQ-010 SHALL have port imem_rdata, input, INSTR_W: memory data, valid one cycle after an enabled read.
REQ-011 SHALL have port next_instruction, output, INSTR_W: instruction presented to IF/ID.
REQ-012 SHALL have port pc_plus_one_IF, output, PC_W: address of next_instruction plus one, presented to IF/ID.
REQ-013 SHALL have port halted, output, 1: high in HALT state.

Function
REQ-014 SHALL keep registers pc_q (address being fetched), pc_d1 (address whose data is on imem_rdata), fetch_valid, and state in {RUN, HALT}.
REQ-015 SHALL drive imem_addr = pc_q combinationally.
REQ-016 SHALL drive imem_en = 1 only when rst_n = 1, state = RUN, and (PCwrite = 1 or branch_taken = 1).
REQ-017 SHALL drive next_instruction = imem_rdata when fetch_valid = 1, else NOP (19'd0).
REQ-018 SHALL drive pc_plus_one_IF = pc_d1 + 1, modulo 2^PC_W (pc_d1 = 8'hFF gives 8'h00).
REQ-019 SHALL, in RUN with PCwrite = 1 and branch_taken = 0, set pc_q <= pc_q+1 (wrapping), pc_d1 <= pc_q, and fetch_valid <= 1.
REQ-020 SHALL, in RUN with PCwrite = 0 and branch_taken = 0, hold pc_q, pc_d1, and fetch_valid, so that outputs are stable for the stall.
REQ-021 SHALL, in RUN with branch_taken = 1, set pc_q <= branch_target and fetch_valid <= 0 (squash the in-flight fetch), regardless of PCwrite; redirect has priority over stall.
REQ-022 SHALL produce the first valid instruction from branch_target one cycle after the redirect edge.
REQ-023 SHALL, in RUN, when fetch_valid = 1, next_instruction[18:14] = OP_HALT (5'b11111), PCwrite = 1, and branch_taken = 0, present HALT to IF/ID for that cycle and then enter HALT with fetch_valid <= 0.
REQ-024 SHALL, in HALT, hold pc_q and pc_d1, output NOP, keep imem_en = 0, and ignore PCwrite and branch_taken.
REQ-025 SHALL leave HALT only via reset.
REQ-026 SHALL, when HALT is on imem_rdata while PCwrite = 0, defer the transition until PCwrite = 1.
REQ-027 SHALL, when HALT is on imem_rdata in the same cycle as branch_taken = 1, take the redirect and not halt.

Reset
REQ-028 SHALL, on rst_n low, asynchronously set pc_q = 0, pc_d1 = 0, fetch_valid = 0, and state = RUN.
REQ-029 SHALL hold these reset output values while rst_n is low: next_instruction = 19'd0, pc_plus_one_IF = 8'd1, imem_addr = 8'd0, imem_en = 0, halted = 0.
REQ-030 SHALL, when reset is asserted mid-operation (including in HALT), discard all state; the first valid instruction is address 0, one enabled cycle after rst_n deasserts.

Structure
REQ-031 SHALL take INSTR_W, PC_W, OP_HALT, the NOP constant, and the state enum from shared package cpu_pkg, which the decode stage also uses.
REQ-032 SHALL isolate the PC next-value mux (increment / hold / redirect) in one sub-module, pc_next, which is combinational; all registers remain in fetch_unit.

Verification
REQ-033 SHALL cover reset then PCwrite = 1 with ROM[i] = i: after the first edge, next_instruction = 0 and pc_plus_one_IF = 1; then 1/2, 2/3 on consecutive cycles.
REQ-034 SHALL cover PCwrite = 0 for 2 cycles while presenting ROM[3]: next_instruction stays 19'd3 and pc_plus_one_IF stays 4; imem_en = 0; resumes with 4/5.
REQ-035 SHALL cover branch_taken = 1, branch_target = 8'h40, asserted together with PCwrite = 0: next cycle NOP; following cycle next_instruction = ROM[0x40] and pc_plus_one_IF = 8'h41.
REQ-036 SHALL cover wrap-around: target 8'hFF gives next_instruction = ROM[0xFF] with pc_plus_one_IF = 8'h00, then ROM[0x00].
REQ-037 SHALL cover ROM[5] = {5'b11111, 14'd0}: HALT is presented once, then NOP; halted = 1; imem_en = 0; branch_taken pulses are ignored.
REQ-038 SHALL cover rst_n pulsed low mid-run and in HALT: outputs go to reset values immediately (asynchronously), then fetch restarts at address 0.
